// File: rtl/gcd_ctrl.sv
// gcd_ctrl: Moore controller sequencing a subtract-based GCD datapath,
// with a start/busy/done handshake and an iteration-limit watchdog.
module gcd_ctrl #(
   parameter int                ITER_W   = 16,
   parameter logic [ITER_W-1:0] MAX_ITER = '1,
   parameter logic [3:0]        OP_EQ    = 4'd0,
   parameter logic [3:0]        OP_LT    = 4'd1,
   parameter logic [3:0]        OP_SUB   = 4'd2,
   parameter logic [3:0]        OP_RSUB  = 4'd3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              D_c,
   output logic [3:0]        S,
   output logic              Xs,
   output logic              Ys,
   output logic              Xld,
   output logic              Yld,
   output logic              Dld,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ITER_W-1:0] iter
);
   typedef enum logic [2:0] {IDLE, LOAD, CMP_EQ, CMP_LT, SUB_X, SUB_Y, OUT, DONE} state_e;
   state_e            state_q, state_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              err_q, err_d;
   logic [3:0]        s_q;
   logic              xs_q, ys_q, xld_q, yld_q, dld_q, busy_q, done_q;
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: if (start) begin
            state_d = LOAD;
            iter_d  = '0;
            err_d   = 1'b0;
         end
         LOAD:   state_d = CMP_EQ;
         CMP_EQ: state_d = D_c ? OUT : CMP_LT;
         CMP_LT: state_d = D_c ? SUB_Y : SUB_X;
         SUB_X, SUB_Y: begin
            iter_d  = (iter_q == MAX_ITER) ? iter_q : iter_q + 1'b1;
            state_d = (iter_d == MAX_ITER) ? OUT : CMP_EQ;
         end
         // reaching OUT with the counter at its limit can only mean a watchdog exit
         OUT: begin
            state_d = DONE;
            err_d   = err_q | (iter_q == MAX_ITER);
         end
         DONE: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         iter_q  <= '0;
         err_q   <= 1'b0;
         s_q     <= 4'd0;
         xs_q    <= 1'b0;
         ys_q    <= 1'b0;
         xld_q   <= 1'b0;
         yld_q   <= 1'b0;
         dld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         err_q   <= err_d;
         s_q     <= (state_d == CMP_EQ || state_d == OUT) ? OP_EQ :
                    (state_d == CMP_LT) ? OP_LT :
                    (state_d == SUB_X)  ? OP_SUB :
                    (state_d == SUB_Y)  ? OP_RSUB : 4'd0;
         xs_q    <= state_d == SUB_X;
         ys_q    <= state_d == SUB_Y;
         xld_q   <= state_d == LOAD || state_d == SUB_X;
         yld_q   <= state_d == LOAD || state_d == SUB_Y;
         dld_q   <= state_d == OUT;
         busy_q  <= state_d != IDLE && state_d != DONE;
         done_q  <= state_d == DONE;
      end
   end
   assign S    = s_q;
   assign Xs   = xs_q;
   assign Ys   = ys_q;
   assign Xld  = xld_q;
   assign Yld  = yld_q;
   assign Dld  = dld_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
   assign iter = iter_q;
endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: drives gcd_ctrl through a behavioural GCD datapath and
// checks results, latency and handshake against a table and scoreboard.
module tb_gcd_ctrl;
   localparam logic [15:0] MAXI = 16'd40;
   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] d;
      logic [15:0] n;
      logic        err;
      int          cyc;
   } vec_t;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, D_c;
   logic [3:0]  S;
   logic        Xs, Ys, Xld, Yld, Dld, busy, done, err;
   logic [15:0] iter, xi, yi, xd, yd, dd, alu;
   int          nchk = 0, nfail = 0;
   vec_t        tbl[10];
   vec_t        exp_q[$];
   gcd_ctrl #(.ITER_W(16), .MAX_ITER(MAXI)) dut (
      .clk(clk), .rst(rst), .start(start), .D_c(D_c), .S(S), .Xs(Xs), .Ys(Ys),
      .Xld(Xld), .Yld(Yld), .Dld(Dld), .busy(busy), .done(done), .err(err), .iter(iter)
   );
   always #5 clk = ~clk;
   always_comb begin
      alu = (S == 4'd0) ? {15'd0, xd == yd} :
            (S == 4'd1) ? {15'd0, xd < yd} :
            (S == 4'd2) ? xd - yd :
            (S == 4'd3) ? yd - xd : 16'd0;
      D_c = alu[0];
   end
   always_ff @(posedge clk) begin
      if (Xld) xd <= Xs ? alu : xi;
      if (Yld) yd <= Ys ? alu : yi;
      if (Dld) dd <= xd;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      nchk++;
      if (act !== want) begin
         nfail++;
         $display("FAIL %s: got %0h, want %0h", name, act, want);
      end
   endtask
   task automatic launch(input vec_t v, input bit hold, input int repulse);
      int   cyc;
      bit   got;
      vec_t e;
      @(negedge clk);
      xi = v.x;
      yi = v.y;
      start = 1'b1;
      exp_q.push_back(v);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = hold;
            chk("load", {busy, Xld, Yld, Xs, Ys, iter, err}, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0});
         end
         if (repulse != 0 && cyc == repulse) start = 1'b1;
         if (repulse != 0 && cyc == repulse + 1) start = 1'b0;
         if (done) got = 1'b1;
      end
      e = exp_q.pop_front();
      if (!got) begin
         nchk++;
         nfail++;
         $display("FAIL timeout %0d/%0d: got no done, want done", e.x, e.y);
      end else begin
         chk("cycles", cyc, e.cyc);
         chk("result", dd, e.d);
         chk("iter", iter, e.n);
         chk("err", err, e.err);
         @(negedge clk);
         chk("pulse", {done, busy}, 2'b00);
      end
   endtask
   task automatic idle_zero(input string name);
      chk(name, {S, Xs, Ys, Xld, Yld, Dld, busy, done, err, iter}, 28'd0);
   endtask
   initial begin
      int  k;
      bit  seen;
      tbl[0] = '{16'd12,   16'd8,   16'd4,  16'd2,  1'b0, 10};
      tbl[1] = '{16'd7,    16'd7,   16'd7,  16'd0,  1'b0, 4};
      tbl[2] = '{16'd1071, 16'd462, 16'd21, 16'd11, 1'b0, 37};
      tbl[3] = '{16'd100,  16'd75,  16'd25, 16'd3,  1'b0, 13};
      tbl[4] = '{16'd13,   16'd5,   16'd1,  16'd5,  1'b0, 19};
      tbl[5] = '{16'd1,    16'd40,  16'd1,  16'd39, 1'b0, 121};
      tbl[6] = '{16'd1,    16'd41,  16'd1,  MAXI,   1'b1, 123};
      tbl[7] = '{16'd5,    16'd0,   16'd5,  MAXI,   1'b1, 123};
      tbl[8] = '{16'd0,    16'd5,   16'd0,  MAXI,   1'b1, 123};
      tbl[9] = '{16'd8,    16'd12,  16'd4,  16'd2,  1'b0, 10};
      xi = 16'd0;
      yi = 16'd0;
      repeat (3) @(negedge clk);
      idle_zero("reset");
      rst = 1'b0;
      for (int i = 0; i < 10; i++) launch(tbl[i], 1'b0, 0);
      launch(tbl[7], 1'b0, 0);
      launch(tbl[0], 1'b0, 3);
      launch(tbl[1], 1'b1, 0);
      @(negedge clk);
      chk("relaunch", {busy, Xld, Yld, iter}, {1'b1, 1'b1, 1'b1, 16'd0});
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_zero("held_rst");
      @(negedge clk);
      xi = 16'd1071;
      yi = 16'd462;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!Ys && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("reach_suby", {Ys, S}, {1'b1, 4'd3});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_zero("mid_rst");
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         seen |= done | busy;
      end
      chk("no_done_after_rst", seen, 1'b0);
      launch(tbl[2], 1'b0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
      $finish;
   end
endmodule
